// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_dataflow.sv
// Single-bit full adder cell in dataflow style.
module full_adder_dataflow (
  output logic sum,
  output logic carry_out,
  input  logic a,
  input  logic b,
  input  logic carry_in
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single full-adder cell,
// LSB first, with valid/ready handshakes on both sides.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_sum_bit;
  logic             w_cout_bit;
  logic             w_last;
  logic [WIDTH-1:0] w_b_load;
  logic             w_cin_load;

  // Subtraction is a + ~b + 1, so only the loaded b and initial carry differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load   = sub ? ~b : b;
  assign w_cin_load = sub ? 1'b1 : carry_in;
`else
  assign w_b_load   = b;
  assign w_cin_load = carry_in;
`endif

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;

  full_adder_dataflow u_fa (
    .sum      (w_sum_bit),
    .carry_out(w_cout_bit),
    .a        (r_a[0]),
    .b        (r_b[0]),
    .carry_in (r_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: accept in IDLE, count bits in RUN, wait for consumer in DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_load;
            r_carry <= w_cin_load;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
          r_carry <= w_cout_bit;
          r_cnt   <= r_cnt + CW'(1);
          // carry_out is a separate register so it holds through IDLE
          // while the working carry is reloaded on the next accept.
          if (w_last) r_cout <= w_cout_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): the driver pushes expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=0x%0h cout=%0b expected none", sum, carry_out);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({carry_out, sum} !== e) begin
          errors++;
          $display("FAIL result: got cout=%0b sum=0x%0h expected cout=%0b sum=0x%0h",
                   carry_out, sum, e[W], e[W-1:0]);
        end
      end
    end
  end

  // Issue one operation, check latency, optionally stall in DONE with in_valid noise.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                       input logic [W-1:0] es, input logic ec,
                       input int stall, input bit noise);
    int n;
    logic [W-1:0] hold_s;
    logic         hold_c;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    a = ta; b = tb_; carry_in = tc; in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_q.push_back({ec, es});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_in_run", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      if (noise) begin
        in_valid = n[0]; a = 8'hFF; b = 8'hEE; carry_in = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(W));
    if (stall > 0) begin
      hold_s = sum; hold_c = carry_out;
      in_valid = 1'b1; a = 8'h99; b = 8'h66;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("stall_sum", 32'(sum), 32'(hold_s));
        chk("stall_cout", 32'(carry_out), 32'(hold_c));
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_after_handshake", 32'(in_ready), 32'd1);
    chk("out_valid_dropped", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 0);
    do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 0, 0);
    do_op(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 5, 0);

    // Reset in the middle of RUN (counter at bit 4): no result may appear.
    a = 8'h55; b = 8'h11; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_reset_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_reset_sum", 32'(sum), 32'd0);
    chk("midrun_reset_cout", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 0, 0);

    do_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 0, 1);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 0, 0);
    do_op(8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 0, 0);
    sub = 1'b0;
    do_op(8'h07, 8'h05, 1'b1, 8'h0D, 1'b0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
